// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if
// Groups the ID-stage instruction fields, the EX zero flag and every control
// output of the pipelined control unit.
//   master : datapath side; drives the instruction fields and zeroE, and
//            receives the control/hazard outputs
//   slave  : control unit side
// REG_ADDR_W sets the register-index width (5 = RV32I, 4 = RV32E).
interface pipelined_control_unit_if #(parameter int REG_ADDR_W = 5);
  logic                  instrValidD;
  logic [6:0]            opcodeD;
  logic [2:0]            f3D;
  logic                  f7b5D;
  logic [REG_ADDR_W-1:0] rs1D;
  logic [REG_ADDR_W-1:0] rs2D;
  logic [REG_ADDR_W-1:0] rdD;
  logic                  zeroE;

  logic [1:0]            immSrcD;
  logic                  illegalD;
  logic [3:0]            ALUControlE;
  logic                  ALUSrcE;
  logic                  PCSrcE;
  logic                  memWriteM;
  logic [1:0]            resultSrcW;
  logic                  regWriteW;
  logic [REG_ADDR_W-1:0] rdW;
  logic [1:0]            forwardAE;
  logic [1:0]            forwardBE;
  logic                  stallF;
  logic                  stallD;
  logic                  flushD;
  logic                  flushE;

  modport master (
    output instrValidD, opcodeD, f3D, f7b5D, rs1D, rs2D, rdD, zeroE,
    input  immSrcD, illegalD, ALUControlE, ALUSrcE, PCSrcE, memWriteM,
           resultSrcW, regWriteW, rdW, forwardAE, forwardBE,
           stallF, stallD, flushD, flushE
  );

  modport slave (
    input  instrValidD, opcodeD, f3D, f7b5D, rs1D, rs2D, rdD, zeroE,
    output immSrcD, illegalD, ALUControlE, ALUSrcE, PCSrcE, memWriteM,
           resultSrcW, regWriteW, rdW, forwardAE, forwardBE,
           stallF, stallD, flushD, flushE
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
// Control and hazard unit for the five-stage Yu Core pipeline. Decodes the
// RV32I subset (R, I-ALU, LW, SW, BEQ/BNE, JAL) in ID, carries control through
// ID/EX, EX/MEM and MEM/WB, resolves branches/jumps in EX and produces the
// stall, flush and forwarding selects.
// Ports:
//   clk     : rising-edge clock
//   resetN  : asynchronous active-low reset; all pipeline registers -> bubble
//   bus     : pipelined_control_unit_if.slave (ID fields, zeroE, all controls)
// Build option:
//   FORWARDING_EN defined   : EX operand forwarding, only load-use stalls
//   FORWARDING_EN undefined : no forwarding; stall on any RAW against EX/MEM
module pipelined_control_unit #(
  parameter int REG_ADDR_W = 5
) (
  input logic                      clk,
  input logic                      resetN,
  pipelined_control_unit_if.slave  bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // An all-zero value of each stage record is the bubble.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic [3:0] alu_ctl;
    logic       alu_src;
    reg_idx_t   rd;
  } ex_ctl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    reg_idx_t   rd;
  } mem_ctl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    reg_idx_t   rd;
  } wb_ctl_t;

  ex_ctl_t    dec;
  ex_ctl_t    idex;
  mem_ctl_t   exmem;
  wb_ctl_t    memwb;
  reg_idx_t   rs1_used;
  reg_idx_t   rs2_used;
  logic       legal;
  logic       use_rs1;
  logic       use_rs2;
  logic [1:0] imm_src;
  logic       is_r;
  logic [3:0] alu_op;
  logic       alu_ok;
  logic       pc_src;
  logic       hazard;
  logic       stall;
  logic       flush_e;
  logic       hit_e;

`ifdef FORWARDING_EN
  reg_idx_t   rs1_e;
  reg_idx_t   rs2_e;
`else
  logic       hit_m;
`endif

  // ALU operation from funct3/funct7[5]. For I-type, funct7[5] is an
  // immediate bit except on the shifts, so it only matters there.
  always_comb begin
    is_r   = (bus.opcodeD == OP_R);
    alu_op = ALU_ADD;
    alu_ok = 1'b1;
    case (bus.f3D)
      3'b000: alu_op = (is_r && bus.f7b5D) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        alu_op = ALU_SLL;
        alu_ok = !bus.f7b5D;
      end
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = bus.f7b5D ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
    if (is_r && bus.f7b5D && (bus.f3D != 3'b000) && (bus.f3D != 3'b101))
      alu_ok = 1'b0;
  end

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_src = 2'b00;
    if (bus.instrValidD) begin
      case (bus.opcodeD)
        OP_R: if (alu_ok) begin
          legal         = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_ctl   = alu_op;
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
        end
        OP_I: if (alu_ok) begin
          legal         = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_ctl   = alu_op;
          dec.alu_src   = 1'b1;
          use_rs1       = 1'b1;
        end
        OP_LW: if (bus.f3D == 3'b010) begin
          legal          = 1'b1;
          dec.reg_write  = 1'b1;
          dec.result_src = RES_MEM;
          dec.alu_src    = 1'b1;
          use_rs1        = 1'b1;
        end
        OP_SW: if (bus.f3D == 3'b010) begin
          legal         = 1'b1;
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          imm_src       = 2'b01;
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
        end
        OP_B: if (bus.f3D[2:1] == 2'b00) begin
          legal         = 1'b1;
          dec.branch    = 1'b1;
          dec.branch_ne = bus.f3D[0];
          dec.alu_ctl   = ALU_SUB;
          imm_src       = 2'b10;
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
        end
        OP_JAL: begin
          legal          = 1'b1;
          dec.reg_write  = 1'b1;
          dec.result_src = RES_PC4;
          dec.jump       = 1'b1;
          imm_src        = 2'b11;
        end
        default: legal = 1'b0;
      endcase
    end
    // rd is carried only for writers and rs only where read, so bubbles,
    // stores, branches and unused fields can never match a hazard compare.
    dec.rd   = dec.reg_write ? bus.rdD : '0;
    rs1_used = use_rs1 ? bus.rs1D : '0;
    rs2_used = use_rs2 ? bus.rs2D : '0;
  end

  assign pc_src = idex.jump | (idex.branch & (bus.zeroE ^ idex.branch_ne));

  assign hit_e = (idex.rd != '0) && ((rs1_used == idex.rd) || (rs2_used == idex.rd));

`ifdef FORWARDING_EN
  assign hazard = (idex.result_src == RES_MEM) && hit_e;

  assign bus.forwardAE =
    (exmem.reg_write && (exmem.rd != '0) && (exmem.rd == rs1_e)) ? 2'b10 :
    (memwb.reg_write && (memwb.rd != '0) && (memwb.rd == rs1_e)) ? 2'b01 : 2'b00;
  assign bus.forwardBE =
    (exmem.reg_write && (exmem.rd != '0) && (exmem.rd == rs2_e)) ? 2'b10 :
    (memwb.reg_write && (memwb.rd != '0) && (memwb.rd == rs2_e)) ? 2'b01 : 2'b00;
`else
  assign hit_m  = (exmem.rd != '0) && ((rs1_used == exmem.rd) || (rs2_used == exmem.rd));
  // WB is not checked: the register file writes before it is read.
  assign hazard = (idex.reg_write && hit_e) || (exmem.reg_write && hit_m);

  assign bus.forwardAE = 2'b00;
  assign bus.forwardBE = 2'b00;
`endif

  // A redirect discards the stalled instruction anyway, so it wins.
  assign stall   = hazard & ~pc_src;
  assign flush_e = stall | pc_src;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
`ifdef FORWARDING_EN
      rs1_e <= '0;
      rs2_e <= '0;
`endif
    end else begin
      idex <= flush_e ? '0 : dec;
`ifdef FORWARDING_EN
      rs1_e <= flush_e ? '0 : rs1_used;
      rs2_e <= flush_e ? '0 : rs2_used;
`endif
      exmem.reg_write  <= idex.reg_write;
      exmem.result_src <= idex.result_src;
      exmem.mem_write  <= idex.mem_write;
      exmem.rd         <= idex.rd;
      memwb.reg_write  <= exmem.reg_write;
      memwb.result_src <= exmem.result_src;
      memwb.rd         <= exmem.rd;
    end
  end

  assign bus.immSrcD     = imm_src;
  assign bus.illegalD    = bus.instrValidD & ~legal;
  assign bus.ALUControlE = idex.alu_ctl;
  assign bus.ALUSrcE     = idex.alu_src;
  assign bus.PCSrcE      = pc_src;
  assign bus.memWriteM   = exmem.mem_write;
  assign bus.resultSrcW  = memwb.result_src;
  assign bus.regWriteW   = memwb.reg_write;
  assign bus.rdW         = memwb.rd;
  assign bus.stallF      = stall;
  assign bus.stallD      = stall;
  assign bus.flushD      = pc_src;
  assign bus.flushE      = flush_e;

endmodule
